// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding the UART transmitter over a valid/ready handshake,
// with an optional idle gap inserted after every transferred byte.
module uart_tx_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 0,
  parameter int GAP_W      = 16,
  parameter int AFULL_LVL  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              flush,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_data_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready
);

  typedef enum logic [0:0] {S_READY, S_GAP} state_e;

  localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  AFULL_C  = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          mem_q [DEPTH];
  logic                wr_accept;
  logic                pop;

  assign full          = (count_q == DEPTH_C);
  assign almost_full   = (count_q >= AFULL_C);
  assign empty         = (count_q == '0);
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign tx_data_valid = (state_q == S_READY) && !empty;
  assign tx_data       = mem_q[rd_ptr_q];

  // full is the registered state, so a write while full drops even if a pop frees a slot.
  assign wr_accept = wr_en && !full && !flush;
  assign pop       = tx_data_valid && tx_ready && !flush;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)       rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (wr_en && full) overflow_d = 1'b1;
      case ({wr_accept, pop})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    if (flush) begin
      state_d   = S_READY;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        S_READY: begin
          if (pop && (GAP_CYCLES > 0)) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == '0) state_d = S_READY;
          else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
        default: begin
          state_d   = S_READY;
          gap_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_READY;
      gap_cnt_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally left out of reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: one back-to-back instance and one with a 3-cycle gap.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Instance A: DEPTH=4, no gap
  logic       a_wr_en = 0, a_flush = 0, a_tx_ready = 0;
  logic [7:0] a_wr_data = 0;
  logic       a_full, a_afull, a_empty, a_ovf, a_vld;
  logic [2:0] a_count;
  logic [7:0] a_data;

  uart_tx_fifo #(.DEPTH(4), .ADDR_W(2), .GAP_CYCLES(0), .GAP_W(16), .AFULL_LVL(3)) u_a (
    .clk(clk), .reset(reset), .wr_en(a_wr_en), .wr_data(a_wr_data), .flush(a_flush),
    .full(a_full), .almost_full(a_afull), .empty(a_empty), .count(a_count),
    .overflow(a_ovf), .tx_data_valid(a_vld), .tx_data(a_data), .tx_ready(a_tx_ready));

  // Instance B: DEPTH=4, gap of 3 cycles
  logic       b_wr_en = 0, b_flush = 0, b_tx_ready = 0;
  logic [7:0] b_wr_data = 0;
  logic       b_full, b_afull, b_empty, b_ovf, b_vld;
  logic [2:0] b_count;
  logic [7:0] b_data;

  uart_tx_fifo #(.DEPTH(4), .ADDR_W(2), .GAP_CYCLES(3), .GAP_W(16), .AFULL_LVL(3)) u_b (
    .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_data(b_wr_data), .flush(b_flush),
    .full(b_full), .almost_full(b_afull), .empty(b_empty), .count(b_count),
    .overflow(b_ovf), .tx_data_valid(b_vld), .tx_data(b_data), .tx_ready(b_tx_ready));

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       ovfa = 0;
  logic       acc_a, pop_a, acc_b, vexp_b;
  int         gapb = 0;
  int         a_pushes = 0, a_pops = 0;
  int         b_pop_cyc[$];

  always @(negedge clk) begin
    if (reset) begin
      qa.delete();
      ovfa = 0;
    end else begin
      chk("a_count", 32'(a_count), qa.size());
      chk("a_vld",   32'(a_vld),   32'(qa.size() != 0));
      chk("a_full",  32'(a_full),  32'(qa.size() == 4));
      chk("a_afull", 32'(a_afull), 32'(qa.size() >= 3));
      chk("a_empty", 32'(a_empty), 32'(qa.size() == 0));
      chk("a_ovf",   32'(a_ovf),   32'(ovfa));
      if (a_flush) begin
        qa.delete();
        ovfa = 0;
      end else begin
        acc_a = a_wr_en && (qa.size() < 4);
        pop_a = (qa.size() != 0) && a_tx_ready;
        if (a_wr_en && !acc_a) ovfa = 1;
        if (pop_a) begin
          chk("a_data", 32'(a_data), 32'(qa.pop_front()));
          a_pops++;
        end
        if (acc_a) begin
          qa.push_back(a_wr_data);
          a_pushes++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      qb.delete();
      gapb = 0;
    end else begin
      vexp_b = (gapb == 0) && (qb.size() != 0);
      chk("b_count", 32'(b_count), qb.size());
      chk("b_vld",   32'(b_vld),   32'(vexp_b));
      acc_b = b_wr_en && (qb.size() < 4);
      if (vexp_b && b_tx_ready) begin
        chk("b_data", 32'(b_data), 32'(qb.pop_front()));
        b_pop_cyc.push_back(cyc);
        gapb = 3;
      end else if (gapb > 0) begin
        gapb--;
      end
      if (acc_b) qb.push_back(b_wr_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_empty", 32'(a_empty), 1);
    chk("rst_full",  32'(a_full),  0);
    chk("rst_afull", 32'(a_afull), 0);
    chk("rst_vld",   32'(a_vld),   0);
    chk("rst_count", 32'(a_count), 0);
    chk("rst_ovf",   32'(a_ovf),   0);
    chk("rst_b_vld", 32'(b_vld),   0);
    @(posedge clk);
    #1;
    reset = 0;

    // Basic
    a_tx_ready = 1;
    a_wr_en = 1; a_wr_data = 8'h41;
    step();
    chk("basic_vld",  32'(a_vld),  1);
    chk("basic_data", 32'(a_data), 'h41);
    a_wr_data = 8'h42;
    step();
    a_wr_en = 0;
    step();
    step();
    chk("basic_empty", 32'(a_empty), 1);

    // Backpressure
    a_tx_ready = 0;
    for (int i = 0; i < 4; i++) begin
      a_wr_en = 1; a_wr_data = 8'(8'h10 + i);
      step();
    end
    a_wr_en = 0;
    step();
    chk("bp_full",  32'(a_full),  1);
    chk("bp_count", 32'(a_count), 4);
    chk("bp_vld",   32'(a_vld),   1);
    chk("bp_data",  32'(a_data),  'h10);
    step();
    chk("bp_hold",  32'(a_data),  'h10);
    a_tx_ready = 1;
    step();
    a_tx_ready = 0;
    chk("bp_pop_count", 32'(a_count), 3);
    chk("bp_pop_data",  32'(a_data),  'h11);

    // Overflow
    a_wr_en = 1; a_wr_data = 8'h14;
    step();
    chk("ov_full", 32'(a_full), 1);
    a_wr_data = 8'h99;
    step();
    chk("ov_count", 32'(a_count), 4);
    chk("ov_flag",  32'(a_ovf),   1);
    a_wr_data = 8'h98; a_tx_ready = 1;
    step();
    a_wr_en = 0; a_tx_ready = 0;
    chk("ovpop_count", 32'(a_count), 3);
    chk("ovpop_flag",  32'(a_ovf),   1);
    chk("ovpop_data",  32'(a_data),  'h12);
    a_flush = 1;
    step();
    a_flush = 0;
    chk("fl_count", 32'(a_count), 0);
    chk("fl_ovf",   32'(a_ovf),   0);
    chk("fl_empty", 32'(a_empty), 1);
    a_flush = 1; a_wr_en = 1; a_wr_data = 8'h77;
    step();
    a_flush = 0; a_wr_en = 0;
    chk("flwr_count", 32'(a_count), 0);
    chk("flwr_ovf",   32'(a_ovf),   0);

    // Wrap
    a_pushes = 0; a_pops = 0;
    for (int i = 0; i < 10; i++) begin
      a_wr_en = 1; a_wr_data = 8'(i);
      a_tx_ready = 1'($urandom_range(1, 0));
      step();
      a_wr_en = 0; a_tx_ready = 1;
      repeat ($urandom_range(2, 1)) step();
    end
    a_tx_ready = 1;
    repeat (4) step();
    chk("wrap_pushes", a_pushes, 10);
    chk("wrap_pops",   a_pops,   10);
    chk("wrap_empty",  32'(a_empty), 1);
    chk("wrap_ovf",    32'(a_ovf),   0);

    // Gap
    b_pop_cyc.delete();
    b_tx_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      b_wr_en = 1; b_wr_data = 8'(i);
      step();
    end
    b_wr_en = 0;
    repeat (14) step();
    chk("gap_npop", b_pop_cyc.size(), 3);
    for (int i = 1; i < b_pop_cyc.size(); i++)
      chk("gap_spacing", b_pop_cyc[i] - b_pop_cyc[i-1], 4);

    // Reset mid-stream
    for (int i = 0; i < 4; i++) begin
      b_wr_en = 1; b_wr_data = 8'(8'hA0 + i);
      step();
    end
    b_wr_en = 0;
    chk("mid_count", 32'(b_count), 3);
    chk("mid_vld",   32'(b_vld),   0);
    #2;
    reset = 1;
    #1;
    chk("arst_empty", 32'(b_empty), 1);
    chk("arst_vld",   32'(b_vld),   0);
    chk("arst_ovf",   32'(b_ovf),   0);
    chk("arst_count", 32'(b_count), 0);
    @(posedge clk);
    #1;
    reset = 0;
    b_wr_en = 1; b_wr_data = 8'h55;
    step();
    b_wr_en = 0;
    chk("post_vld",  32'(b_vld),  1);
    chk("post_data", 32'(b_data), 'h55);
    repeat (3) step();
    chk("post_drain", qb.size(), 0);
    chk("post_empty", 32'(b_empty), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
